execute_stage_md: RTL

//  XLEN-parametrised execute stage with RV M-extension support: single-cycle integer ALU, single-cycle

---
 rtl/execute_stage_md.sv | 346 ++++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/execute_stage_md.sv
// execute_stage_md: execute stage with integer ALU, RV-M multiply/divide and branch resolution.
// ALU and multiply results register on the next edge. Divides iterate one restoring step per
// cycle and hold the upstream pipeline through busy_stall_ao.
module execute_stage_md #(
  parameter int unsigned XLEN  = 64,
  parameter bit          M_EXT = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            squash_i,
  input  logic            stall_i,
  input  logic            valid_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic [15:0]     alu_op_1h_i,
  input  logic [XLEN-1:0] alu_op_a_i,
  input  logic [XLEN-1:0] alu_op_b_i,
  input  logic            alu_uses_rs1_i,
  input  logic            alu_uses_rs2_i,
  input  logic            md_en_i,
  input  logic [2:0]      md_op_i,
  input  logic            md_word_i,
  input  logic [4:0]      rd_idx_i,
  input  logic            rd_wr_en_i,
  input  logic            pc_src_i,
  input  logic [5:0]      br_cond_1h_i,
  output logic            target_sel_o,
  output logic [XLEN-1:0] target_addr_o,
  output logic            busy_stall_ao,
  output logic            valid_o,
  output logic [XLEN-1:0] res_o,
  output logic [4:0]      rd_idx_o,
  output logic            rd_wr_en_o
);

  localparam int unsigned SW = $clog2(XLEN);
  localparam int unsigned CW = $clog2(XLEN + 1);

  // One-hot ALU operation bit positions
  localparam int unsigned ALU_ADD   = 0;
  localparam int unsigned ALU_SUB   = 1;
  localparam int unsigned ALU_SLL   = 2;
  localparam int unsigned ALU_SLT   = 3;
  localparam int unsigned ALU_SLTU  = 4;
  localparam int unsigned ALU_XOR   = 5;
  localparam int unsigned ALU_SRL   = 6;
  localparam int unsigned ALU_SRA   = 7;
  localparam int unsigned ALU_OR    = 8;
  localparam int unsigned ALU_AND   = 9;
  localparam int unsigned ALU_PASSB = 10;
  localparam int unsigned ALU_ADDW  = 11;
  localparam int unsigned ALU_SUBW  = 12;
  localparam int unsigned ALU_SLLW  = 13;
  localparam int unsigned ALU_SRLW  = 14;
  localparam int unsigned ALU_SRAW  = 15;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    logic [XLEN-1:0] r;
    r = '0;
    r[31:0] = v;
    for (int i = 32; i < XLEN; i++) r[i] = v[31];
    return r;
  endfunction

  function automatic logic [XLEN-1:0] zext32(input logic [31:0] v);
    logic [XLEN-1:0] r;
    r = '0;
    r[31:0] = v;
    return r;
  endfunction

  logic            valid;
  logic            md_en_eff;
  logic            word_eff;
  logic [XLEN-1:0] alu_a;
  logic [XLEN-1:0] alu_b;
  logic [SW-1:0]   shamt;
  logic [XLEN-1:0] alu_result;
  logic [XLEN-1:0] md_result;
  logic            busy_stall;
  logic            br_eq;
  logic            br_lt;
  logic            br_ltu;
  logic [5:0]      br_flags;
  logic            br_taken;

  logic            valid_q, valid_d;
  logic [XLEN-1:0] res_q, res_d;
  logic [4:0]      rd_idx_q, rd_idx_d;
  logic            rd_wr_en_q, rd_wr_en_d;

  assign valid     = valid_i & ~squash_i;
  assign md_en_eff = M_EXT ? md_en_i : 1'b0;
  // W variants only exist on a 64-bit datapath
  assign word_eff  = (XLEN == 64) ? md_word_i : 1'b0;

  // Integer ALU: operand select and one-hot operation mux
  always_comb begin
    alu_a      = alu_uses_rs1_i ? rs1_data_i : alu_op_a_i;
    alu_b      = alu_uses_rs2_i ? rs2_data_i : alu_op_b_i;
    shamt      = alu_b[SW-1:0];
    alu_result = '0;
    case (1'b1)
      alu_op_1h_i[ALU_ADD]:   alu_result = alu_a + alu_b;
      alu_op_1h_i[ALU_SUB]:   alu_result = alu_a - alu_b;
      alu_op_1h_i[ALU_SLL]:   alu_result = alu_a << shamt;
      alu_op_1h_i[ALU_SLT]:   alu_result = {{(XLEN-1){1'b0}}, $signed(alu_a) < $signed(alu_b)};
      alu_op_1h_i[ALU_SLTU]:  alu_result = {{(XLEN-1){1'b0}}, alu_a < alu_b};
      alu_op_1h_i[ALU_XOR]:   alu_result = alu_a ^ alu_b;
      alu_op_1h_i[ALU_SRL]:   alu_result = alu_a >> shamt;
      alu_op_1h_i[ALU_SRA]:   alu_result = $unsigned($signed(alu_a) >>> shamt);
      alu_op_1h_i[ALU_OR]:    alu_result = alu_a | alu_b;
      alu_op_1h_i[ALU_AND]:   alu_result = alu_a & alu_b;
      alu_op_1h_i[ALU_PASSB]: alu_result = alu_b;
      alu_op_1h_i[ALU_ADDW]:  alu_result = sext32(alu_a[31:0] + alu_b[31:0]);
      alu_op_1h_i[ALU_SUBW]:  alu_result = sext32(alu_a[31:0] - alu_b[31:0]);
      alu_op_1h_i[ALU_SLLW]:  alu_result = sext32(alu_a[31:0] << alu_b[4:0]);
      alu_op_1h_i[ALU_SRLW]:  alu_result = sext32(alu_a[31:0] >> alu_b[4:0]);
      alu_op_1h_i[ALU_SRAW]:  alu_result = sext32($unsigned($signed(alu_a[31:0]) >>> alu_b[4:0]));
      default:                alu_result = '0;
    endcase
  end

  // Branch resolution: a malformed (non one-hot) condition never redirects
  always_comb begin
    br_eq    = (rs1_data_i == rs2_data_i);
    br_lt    = ($signed(rs1_data_i) < $signed(rs2_data_i));
    br_ltu   = (rs1_data_i < rs2_data_i);
    br_flags = {~br_ltu, br_ltu, ~br_lt, br_lt, ~br_eq, br_eq};
    br_taken = $onehot(br_cond_1h_i) && (|(br_cond_1h_i & br_flags));
  end

  assign target_sel_o  = valid & ~md_en_eff & (pc_src_i | br_taken);
  assign target_addr_o = alu_result;
  assign busy_stall_ao = busy_stall;

  generate
    if (M_EXT) begin : g_md
      div_state_e        state_q, state_d;
      logic [XLEN-1:0]   quo_q, quo_d;
      logic [XLEN-1:0]   rem_q, rem_d;
      logic [XLEN-1:0]   dvs_q, dvs_d;
      logic [CW-1:0]     cnt_q, cnt_d;
      logic              neg_q, neg_d;
      logic              rneg_q, rneg_d;
      logic              is_rem_q, is_rem_d;
      logic              word_q, word_d;

      logic              is_div;
      logic              div_signed;
      logic              div_start;
      logic              div_special;
      logic              dvd_neg, dvs_neg, dvs_zero, div_ovf;
      logic [XLEN-1:0]   dvd_raw, dvs_raw, dvd_abs, dvs_abs, min_val;
      logic [XLEN:0]     shifted, trial;
      logic              mul_a_sgn, mul_b_sgn;
      logic [2*XLEN-1:0] mul_a, mul_b, mul_prod;
      logic [XLEN-1:0]   mul_res, div_res, q_fin, r_fin, div_sel;

      // Divide operand conditioning and special-case detection
      always_comb begin
        is_div     = md_op_i[2];
        div_signed = ~md_op_i[0];
        if (word_eff) begin
          dvd_raw = div_signed ? sext32(rs1_data_i[31:0]) : zext32(rs1_data_i[31:0]);
          dvs_raw = div_signed ? sext32(rs2_data_i[31:0]) : zext32(rs2_data_i[31:0]);
          min_val = sext32(32'h8000_0000);
        end else begin
          dvd_raw = rs1_data_i;
          dvs_raw = rs2_data_i;
          min_val = {1'b1, {(XLEN-1){1'b0}}};
        end
        dvd_neg     = div_signed & dvd_raw[XLEN-1];
        dvs_neg     = div_signed & dvs_raw[XLEN-1];
        dvd_abs     = dvd_neg ? -dvd_raw : dvd_raw;
        dvs_abs     = dvs_neg ? -dvs_raw : dvs_raw;
        dvs_zero    = (dvs_raw == '0);
        div_ovf     = div_signed & (dvd_raw == min_val) & (dvs_raw == '1);
        div_special = dvs_zero | div_ovf;
        div_start   = valid & md_en_i & is_div & ~stall_i;
      end

      // Single-cycle multiplier: operands extended to 2*XLEN so one product covers all MULH forms
      always_comb begin
        mul_a_sgn = (md_op_i[1:0] == 2'd1) | (md_op_i[1:0] == 2'd2);
        mul_b_sgn = (md_op_i[1:0] == 2'd1);
        mul_a     = {{XLEN{mul_a_sgn & rs1_data_i[XLEN-1]}}, rs1_data_i};
        mul_b     = {{XLEN{mul_b_sgn & rs2_data_i[XLEN-1]}}, rs2_data_i};
        mul_prod  = mul_a * mul_b;
        if (md_op_i[1:0] == 2'd0) begin
          mul_res = word_eff ? sext32(mul_prod[31:0]) : mul_prod[XLEN-1:0];
        end else begin
          mul_res = mul_prod[2*XLEN-1:XLEN];
        end
      end

      // Divider state register
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= DIV_IDLE;
        else         state_q <= state_d;
      end

      // Divider next-state: squash always returns to IDLE
      always_comb begin
        state_d = state_q;
        if (squash_i) begin
          state_d = DIV_IDLE;
        end else begin
          case (state_q)
            DIV_IDLE: if (div_start) state_d = div_special ? DIV_DONE : DIV_BUSY;
            DIV_BUSY: if (cnt_q == CW'(1)) state_d = DIV_DONE;
            DIV_DONE: if (!stall_i) state_d = DIV_IDLE;
            default:  state_d = DIV_IDLE;
          endcase
        end
      end

      // Divider datapath: latch on start, one restoring step per BUSY cycle
      always_comb begin
        quo_d    = quo_q;
        rem_d    = rem_q;
        dvs_d    = dvs_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        is_rem_d = is_rem_q;
        word_d   = word_q;
        shifted  = {rem_q, quo_q[XLEN-1]};
        trial    = shifted - {1'b0, dvs_q};
        case (state_q)
          DIV_IDLE: begin
            if (div_start) begin
              is_rem_d = md_op_i[1];
              word_d   = word_eff;
              if (div_special) begin
                // Results are final here; sign fix-up is disabled
                quo_d  = dvs_zero ? '1 : dvd_raw;
                rem_d  = dvs_zero ? dvd_raw : '0;
                dvs_d  = dvs_raw;
                neg_d  = 1'b0;
                rneg_d = 1'b0;
                cnt_d  = '0;
              end else begin
                // W dividends are left-aligned so N=32 steps consume exactly their bits
                quo_d  = word_eff ? (dvd_abs << 32) : dvd_abs;
                rem_d  = '0;
                dvs_d  = dvs_abs;
                neg_d  = dvd_neg ^ dvs_neg;
                rneg_d = dvd_neg;
                cnt_d  = word_eff ? CW'(32) : CW'(XLEN);
              end
            end
          end
          DIV_BUSY: begin
            if (!trial[XLEN]) begin
              rem_d = trial[XLEN-1:0];
              quo_d = {quo_q[XLEN-2:0], 1'b1};
            end else begin
              rem_d = shifted[XLEN-1:0];
              quo_d = {quo_q[XLEN-2:0], 1'b0};
            end
            cnt_d = cnt_q - 1'b1;
          end
          default: ;
        endcase
      end

      // Divider datapath registers
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          quo_q    <= '0;
          rem_q    <= '0;
          dvs_q    <= '0;
          cnt_q    <= '0;
          neg_q    <= 1'b0;
          rneg_q   <= 1'b0;
          is_rem_q <= 1'b0;
          word_q   <= 1'b0;
        end else begin
          quo_q    <= quo_d;
          rem_q    <= rem_d;
          dvs_q    <= dvs_d;
          cnt_q    <= cnt_d;
          neg_q    <= neg_d;
          rneg_q   <= rneg_d;
          is_rem_q <= is_rem_d;
          word_q   <= word_d;
        end
      end

      // Divider outputs: sign fix-up, result select and upstream hold
      always_comb begin
        q_fin      = neg_q ? -quo_q : quo_q;
        r_fin      = rneg_q ? -rem_q : rem_q;
        div_sel    = is_rem_q ? r_fin : q_fin;
        div_res    = word_q ? sext32(div_sel[31:0]) : div_sel;
        md_result  = is_div ? div_res : mul_res;
        busy_stall = valid & md_en_i & is_div & (state_q != DIV_DONE);
      end
    end else begin : g_no_md
      assign md_result  = '0;
      assign busy_stall = 1'b0;
    end
  endgenerate

  // Pipeline output next-state: hold on downstream stall, bubble while a divide is pending
  always_comb begin
    valid_d    = valid_q;
    res_d      = res_q;
    rd_idx_d   = rd_idx_q;
    rd_wr_en_d = rd_wr_en_q;
    if (!stall_i) begin
      valid_d    = valid & ~busy_stall;
      res_d      = md_en_eff ? md_result : alu_result;
      rd_idx_d   = rd_idx_i;
      rd_wr_en_d = rd_wr_en_i;
    end
  end

  // Pipeline output registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q    <= 1'b0;
      res_q      <= '0;
      rd_idx_q   <= '0;
      rd_wr_en_q <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      res_q      <= res_d;
      rd_idx_q   <= rd_idx_d;
      rd_wr_en_q <= rd_wr_en_d;
    end
  end

  assign valid_o    = valid_q;
  assign res_o      = res_q;
  assign rd_idx_o   = rd_idx_q;
  assign rd_wr_en_o = rd_wr_en_q;

endmodule
